mmul_stream_core: RTL and testbench
===================================

MMUL_STREAM_CORE -- requirements
Module: mmul_stream_core

Interface
REQ-001 SHALL have parameter RA, default 2, rows of matrix A.
REQ-002 SHALL have parameter CA, default 2, columns of A; inner dimension.
REQ-003 SHALL have parameter RB, default 2, rows of B; used only for B storage/count sizing.
REQ-004 SHALL have parameter CB, default 2, columns of B.
REQ-005 SHALL have parameter W, default 8, signed input element width.
REQ-006 SHALL have localparam ACC_W = 2*W + $clog2(CA), output element width.
REQ-007 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 SHALL have port dims_valid  input  1  dimension-check result from upstream validator; 1 = dimensions legal.
REQ-010 SHALL have port in_valid  input  1  in_data carries an element.
REQ-011 SHALL have port in_ready  output  1  block accepts an element this cycle.
REQ-012 SHALL have port in_data  input  W  signed element of A, then B, row-major.
REQ-013 SHALL have port out_valid  output  1  out_data carries a C element.
REQ-014 SHALL have port out_ready  input  1  consumer accepts a C element.
REQ-015 SHALL have port out_data  output  ACC_W  signed C element, row-major.
REQ-016 SHALL have port busy  output  1  high in any state except LOAD_A with zero elements accepted.
REQ-017 SHALL have port err  output  1  high while a job is blocked by dims_valid=0.

Function
REQ-018 SHALL implement FSM states LOAD_A, LOAD_B, MAC, EMIT; reset state LOAD_A.
REQ-019 SHALL transfer an input element only on a cycle with in_valid=1 and in_ready=1.
REQ-020 SHALL transfer an output element only on a cycle with out_valid=1 and out_ready=1.
REQ-021 SHALL drive in_ready=1 only in LOAD_A/LOAD_B; in LOAD_A with zero accepted elements, only when dims_valid=1.
REQ-022 SHALL, in LOAD_A with zero accepted elements and dims_valid=0, drive registered err=1 the next cycle and hold there; err clears the cycle after dims_valid returns to 1.
REQ-023 SHALL ignore dims_valid once the first A element of a job is accepted.
REQ-024 SHALL store RA*CA A elements then RB*CB B elements, row-major; LOAD_A->LOAD_B on the last A transfer, LOAD_B->MAC on the last B transfer.
REQ-025 SHALL compute C[i][j] = sum over k of A[i][k]*B[k][j], signed, full ACC_W precision, no saturation or truncation.
REQ-026 SHALL spend exactly CA cycles in MAC per C element, one product per cycle, k ascending, accumulator cleared at k=0.
REQ-027 SHALL enter EMIT after the CA-th MAC cycle, holding out_valid=1 and out_data stable until the transfer.
REQ-028 SHALL, given last B transfer at cycle t, assert out_valid first at cycle t+CA+1.
REQ-029 SHALL, given an output transfer at cycle u not the last, run MAC u+1..u+CA and assert out_valid again at u+CA+1; out_valid low during MAC.
REQ-030 SHALL emit C in row-major order, index j wrapping to 0 and i incrementing after CB elements.
REQ-031 SHALL return to LOAD_A with zero accepted elements after the RA*CB-th output transfer; in_ready may rise the next cycle.
REQ-032 SHALL keep out_valid=0 in LOAD_A, LOAD_B, MAC.

Reset
REQ-033 SHALL, on rst_n=0 at any time including mid-job, immediately force state LOAD_A, all counters 0, accumulator 0, in_ready=0, out_valid=0, out_data=0, busy=0, err=0.
REQ-034 SHALL keep A/B storage contents unreset; they are don't-care until rewritten.
REQ-035 SHALL allow in_ready=1 on the first rising edge after rst_n deasserts when dims_valid=1.

Verification
REQ-036 SHALL cover 2x2: A=[1,2;3,4], B=[5,6;7,8], out_ready=1 -> outputs 19,22,43,50 in order; first out_valid 3 cycles after last B transfer.
REQ-037 SHALL cover signed extremes, RA=CA=RB=CB=1, W=8: A=-128, B=-128 -> out_data=16384; A=-128, B=127 -> -16256.
REQ-038 SHALL cover backpressure: 2x2 case with out_ready=0 for 5 cycles at each EMIT -> out_data stable, values unchanged, no input accepted.
REQ-039 SHALL cover dims_valid=0 at reset release -> in_ready=0, err=1 from next cycle; raise dims_valid -> err=0 next cycle, job then completes correctly.
REQ-040 SHALL cover reset mid-MAC -> all outputs at reset values; a fresh 2x2 job afterwards yields 19,22,43,50.
REQ-041 SHALL cover in_valid toggling randomly during loading -> only handshaked elements stored, results match reference product.

Source files
------------

// File: rtl/mmul_stream_core.sv
// -----------------------------------------------------------------------------
// mmul_stream_core
//
// Streaming matrix multiplier C = A * B.  A (RA x CA) and then B (RB x CB) are
// loaded one signed element per handshake, row-major.  Each C element is then
// computed by a serial multiply-accumulate over the inner dimension (one
// product per cycle) and presented on a valid/ready output port, row-major.
// The product is kept at full ACC_W precision: no saturation, no truncation.
// A new job can start only after the last C element of the previous job has
// been accepted.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   dims_valid : upstream dimension check result; gates the start of a job
//   in_valid   : in_data carries an element
//   in_ready   : block accepts an element this cycle
//   in_data    : signed element, A first then B, row-major
//   out_valid  : out_data carries a C element
//   out_ready  : consumer accepts the C element
//   out_data   : signed C element, ACC_W bits, row-major
//   busy       : a job is in progress (anything but idle LOAD_A)
//   err        : registered; job start blocked because dims_valid is low
// -----------------------------------------------------------------------------
module mmul_stream_core #(
  parameter int RA = 2,
  parameter int CA = 2,
  parameter int RB = 2,
  parameter int CB = 2,
  parameter int W  = 8,
  localparam int ACC_W = 2 * W + $clog2(CA)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dims_valid,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W-1:0]     in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    busy,
  output logic                    err
);

  localparam int A_N   = RA * CA;
  localparam int B_N   = RB * CB;
  localparam int MAX_N = (A_N > B_N) ? A_N : B_N;
  localparam int LD_W  = $clog2(MAX_N) + 1;
  localparam int A_AW  = (A_N > 1) ? $clog2(A_N) : 1;
  localparam int B_AW  = (B_N > 1) ? $clog2(B_N) : 1;
  localparam int K_W   = $clog2(CA) + 1;
  localparam int I_W   = $clog2(RA) + 1;
  localparam int J_W   = $clog2(CB) + 1;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    MAC,
    EMIT
  } state_e;

  // Operand storage
  logic signed [W-1:0] a_mem [A_N];
  logic signed [W-1:0] b_mem [B_N];

  // State
  state_e                   state_q,     state_d;
  logic [LD_W-1:0]          ld_cnt_q,    ld_cnt_d;
  logic [K_W-1:0]           k_q,         k_d;
  logic [I_W-1:0]           i_q,         i_d;
  logic [J_W-1:0]           j_q,         j_d;
  logic signed [ACC_W-1:0]  acc_q,       acc_d;
  logic signed [ACC_W-1:0]  out_data_q,  out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     err_q,       err_d;
  // Low only during reset and for the first edge after it, so that in_ready
  // stays low while rst_n is asserted.
  logic                     live_q,      live_d;

  // Datapath
  logic                     idle;
  logic                     in_fire;
  logic                     out_fire;
  logic [A_AW-1:0]          a_rd_idx;
  logic [B_AW-1:0]          b_rd_idx;
  logic signed [2*W-1:0]    prod;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  mac_sum;

  // Idle means "LOAD_A with nothing accepted yet": only here does dims_valid
  // matter; once the first A element is in, it is ignored.
  assign idle     = (state_q == LOAD_A) && (ld_cnt_q == '0);
  assign in_ready = live_q && (((state_q == LOAD_A) && (!idle || dims_valid)) ||
                               (state_q == LOAD_B));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err       = err_q;
  assign busy      = !idle;

  // A[i][k] and B[k][j]; B rows are indexed by the inner dimension.
  always_comb begin
    a_rd_idx = A_AW'(int'(i_q) * CA + int'(k_q));
    b_rd_idx = B_AW'(int'(k_q) * CB + int'(j_q));
    prod     = a_mem[a_rd_idx] * b_mem[b_rd_idx];
    // The accumulator restarts at k = 0, so a stale sum never leaks forward.
    acc_base = (k_q == '0) ? '0 : acc_q;
    mac_sum  = acc_base + ACC_W'(prod);
  end

  // NOTE: every variable gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    k_d         = k_q;
    i_d         = i_q;
    j_d         = j_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = idle && !dims_valid;
    live_d      = 1'b1;

    unique case (state_q)
      LOAD_A: begin
        if (in_fire) begin
          if (ld_cnt_q == LD_W'(A_N - 1)) begin
            ld_cnt_d = '0;
            state_d  = LOAD_B;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      end

      LOAD_B: begin
        if (in_fire) begin
          if (ld_cnt_q == LD_W'(B_N - 1)) begin
            ld_cnt_d = '0;
            k_d      = '0;
            i_d      = '0;
            j_d      = '0;
            state_d  = MAC;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      end

      MAC: begin
        acc_d = mac_sum;
        if (k_q == K_W'(CA - 1)) begin
          k_d         = '0;
          out_data_d  = mac_sum;
          out_valid_d = 1'b1;
          state_d     = EMIT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      EMIT: begin
        // out_data_q is held untouched until the consumer takes it.
        if (out_fire) begin
          out_valid_d = 1'b0;
          state_d     = MAC;
          if (j_q == J_W'(CB - 1)) begin
            j_d = '0;
            if (i_q == I_W'(RA - 1)) begin
              i_d     = '0;
              state_d = LOAD_A;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end

      default: state_d = LOAD_A;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      ld_cnt_q    <= '0;
      k_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      k_q         <= k_d;
      i_q         <= i_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      live_q      <= live_d;
    end
  end

  // NOTE: operand memories have no reset; every entry is rewritten by a job
  // before the MAC phase reads it.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (state_q == LOAD_A) begin
        a_mem[A_AW'(ld_cnt_q)] <= in_data;
      end else begin
        b_mem[B_AW'(ld_cnt_q)] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_mmul_stream_core.sv
// -----------------------------------------------------------------------------
// tb_mmul_stream_core
//
// Scoreboard bench for mmul_stream_core.  Each job pushes the reference matrix
// product (plain nested-loop arithmetic) into a queue; an independent monitor
// pops and compares on every output handshake and also checks emit latency,
// data hold under backpressure and that no input is taken while emitting.
// A second 1x1 instance covers signed extremes at minimum size.
// -----------------------------------------------------------------------------
module tb_mmul_stream_core;

  localparam int RA     = 2;
  localparam int CA     = 2;
  localparam int RB     = 2;
  localparam int CB     = 2;
  localparam int W      = 8;
  localparam int ACC_W  = 2 * W + $clog2(CA);
  localparam int ACC1_W = 2 * W;
  localparam int A_N    = RA * CA;
  localparam int B_N    = RB * CB;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     dims_valid;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [W-1:0]      in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic                     busy;
  logic                     err;

  logic                     d1_in_valid;
  logic                     d1_in_ready;
  logic signed [W-1:0]      d1_in_data;
  logic                     d1_out_valid;
  logic                     d1_out_ready;
  logic signed [ACC1_W-1:0] d1_out_data;
  logic                     d1_busy;
  logic                     d1_err;

  int n_vec = 0;
  int n_bad = 0;
  int exp_q[$];
  int ob_mode = 0;  // 0: always ready, 1: random, 2: 5-cycle stall per element

  int a_basic[A_N] = '{1, 2, 3, 4};
  int b_basic[B_N] = '{5, 6, 7, 8};

  always #5 clk = ~clk;

  mmul_stream_core #(.RA(RA), .CA(CA), .RB(RB), .CB(CB), .W(W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dims_valid (dims_valid),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .err        (err)
  );

  mmul_stream_core #(.RA(1), .CA(1), .RB(1), .CB(1), .W(W)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .dims_valid (1'b1),
    .in_valid   (d1_in_valid),
    .in_ready   (d1_in_ready),
    .in_data    (d1_in_data),
    .out_valid  (d1_out_valid),
    .out_ready  (d1_out_ready),
    .out_data   (d1_out_data),
    .busy       (d1_busy),
    .err        (d1_err)
  );

  task automatic check(input string name, input int got, input int exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp_v, $time);
    end
  endtask

  // Reference model: C[i][j] = sum_k A[i][k] * B[k][j], row-major order.
  function automatic void push_expected(input int a[A_N], input int b[B_N]);
    for (int i = 0; i < RA; i++) begin
      for (int j = 0; j < CB; j++) begin
        int s = 0;
        for (int k = 0; k < CA; k++) s += a[i * CA + k] * b[k * CB + j];
        exp_q.push_back(s);
      end
    end
  endfunction

  // Offer one element until it is handshaked; in_valid may toggle randomly.
  task automatic send(input logic signed [W-1:0] v, input bit rnd);
    int  tries = 0;
    bit  done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      in_valid = rnd ? 1'($urandom_range(1)) : 1'b1;
      in_data  = v;
      #1;
      if (in_valid && in_ready) begin
        done = 1'b1;
      end else if (++tries > 300) begin
        n_vec++;
        n_bad++;
        $display("FAIL in_handshake_timeout: in_ready stuck at %0b, expected 1", in_ready);
        done = 1'b1;
      end
    end
  endtask

  task automatic run_job(input int a[A_N], input int b[B_N], input bit rnd, input bit drop);
    push_expected(a, b);
    for (int i = 0; i < A_N; i++) begin
      send(W'(a[i]), rnd);
      if (i == 0 && drop) begin
        @(posedge clk);
        #1;
        dims_valid = 1'($urandom_range(1));
      end
    end
    for (int i = 0; i < B_N; i++) send(W'(b[i]), rnd);
    @(negedge clk);
    in_valid   = 1'b0;
    dims_valid = 1'b1;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  // 1x1 instance: product, latency CA+1 = 2, clean return to idle.
  task automatic run1(input int a, input int b);
    int t;
    int lat;
    int exp_v = a * b;
    @(negedge clk);
    d1_in_valid = 1'b1;
    d1_in_data  = W'(a);
    #1;
    t = 0;
    while (!d1_in_ready && t < 50) begin @(negedge clk); #1; t++; end
    check("d1_a_accept", int'(d1_in_ready), 1);
    @(negedge clk);
    d1_in_data = W'(b);
    #1;
    t = 0;
    while (!d1_in_ready && t < 50) begin @(negedge clk); #1; t++; end
    check("d1_b_accept", int'(d1_in_ready), 1);
    @(negedge clk);
    d1_in_valid = 1'b0;
    #1;
    lat = 1;
    while (!d1_out_valid && lat < 50) begin @(negedge clk); #1; lat++; end
    check("d1_latency", lat, 2);
    check("d1_product", int'(d1_out_data), exp_v);
    d1_out_ready = 1'b1;
    @(negedge clk);
    d1_out_ready = 1'b0;
    #1;
    check("d1_valid_after", int'(d1_out_valid), 0);
    check("d1_busy_after", int'(d1_busy), 0);
  endtask

  // Consumer side.
  initial begin
    int stall_cnt = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ob_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(1));
        default: begin
          if (!out_valid) stall_cnt = 0;
          if (out_valid && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
          end else begin
            out_ready = out_valid;
          end
        end
      endcase
    end
  end

  // Monitor: samples mid-cycle, after inputs and outputs have settled.
  initial begin
    int cyc     = 0;
    int ref_cyc = -1;
    int in_cnt  = 0;
    bit prev_stall = 1'b0;
    bit prev_valid = 1'b0;
    int prev_data  = 0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        in_cnt     = 0;
        ref_cyc    = -1;
        prev_stall = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_data", int'(out_data), prev_data);
        end
        if (out_valid) check("no_input_while_emit", int'(in_ready), 0);
        if (out_valid && !prev_valid && ref_cyc >= 0)
          check("emit_latency", cyc - ref_cyc, CA + 1);
        if (in_valid && in_ready) begin
          in_cnt++;
          if (in_cnt == A_N + B_N) begin
            in_cnt  = 0;
            ref_cyc = cyc;
          end
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_output: got %0d, expected no output", out_data);
          end else begin
            check("c_element", int'(out_data), exp_q.pop_front());
          end
          ref_cyc = cyc;
        end
        prev_stall = out_valid && !out_ready;
        prev_valid = out_valid;
        prev_data  = int'(out_data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    rst_n        = 1'b0;
    dims_valid   = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    d1_in_valid  = 1'b0;
    d1_in_data   = '0;
    d1_out_ready = 1'b0;

    #23;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    check("rst_d1_in_ready", int'(d1_in_ready), 0);

    // Release reset with dims_valid low: job start must be blocked.
    dims_valid = 1'b0;
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("blocked_in_ready", int'(in_ready), 0);
    check("blocked_err", int'(err), 1);
    check("blocked_busy", int'(busy), 0);
    repeat (2) begin
      @(negedge clk);
      #1;
      check("blocked_err_hold", int'(err), 1);
    end
    @(negedge clk);
    dims_valid = 1'b1;
    #1;
    check("err_same_cycle", int'(err), 1);
    check("unblocked_in_ready", int'(in_ready), 1);
    @(negedge clk);
    #1;
    check("err_cleared", int'(err), 0);

    // Basic 2x2 job: 19, 22, 43, 50.
    ob_mode = 0;
    run_job(a_basic, b_basic, 1'b0, 1'b0);
    drain();

    // Signed extremes at 1x1.
    run1(-128, -128);
    run1(-128, 127);

    // Backpressure: five stalled cycles at every emitted element.
    ob_mode = 2;
    run_job(a_basic, b_basic, 1'b0, 1'b0);
    drain();
    ob_mode = 0;

    // Signed extremes at 2x2 exercise the extra accumulator bit.
    begin
      int a_x[A_N] = '{-128, -128, -128, -128};
      int b_x[B_N] = '{-128, -128, -128, -128};
      int b_y[B_N] = '{127, 127, 127, 127};
      run_job(a_x, b_x, 1'b0, 1'b0);
      drain();
      run_job(a_x, b_y, 1'b0, 1'b0);
      drain();
    end

    // Reset during MAC, then a fresh job.
    run_job(a_basic, b_basic, 1'b0, 1'b0);
    #1;
    check("mac_busy", int'(busy), 1);
    check("mac_out_valid", int'(out_valid), 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    #4 rst_n = 1'b1;
    run_job(a_basic, b_basic, 1'b0, 1'b0);
    drain();

    // Randomized jobs with toggling in_valid, random out_ready, and dims_valid
    // wiggling after the first accepted A element.
    for (int n = 0; n < 25; n++) begin
      int a_r[A_N];
      int b_r[B_N];
      foreach (a_r[i]) a_r[i] = int'($urandom_range(255)) - 128;
      foreach (b_r[i]) b_r[i] = int'($urandom_range(255)) - 128;
      ob_mode = int'($urandom_range(1));
      run_job(a_r, b_r, 1'b1, 1'b1);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
